// File: rtl/predictor_pkg.sv
// -----------------------------------------------------------------------------
// predictor_pkg
// Shared definitions for the branch-predictor epoch controller: the default
// counter width and the controller FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package predictor_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage : predictor_pkg

// File: rtl/predictor_epoch_ctrl_if.sv
// -----------------------------------------------------------------------------
// predictor_epoch_ctrl_if
// Report channel of the epoch controller: a valid/ready snapshot carrying the
// branch count, miss count and a flag marking stop-triggered (partial) reports.
//   valid   : snapshot available                    (master -> slave)
//   ready   : consumer accepts when valid && ready  (slave  -> master)
//   br      : branches in reported epoch            (master -> slave)
//   miss    : misses in reported epoch              (master -> slave)
//   partial : report produced by stop               (master -> slave)
// -----------------------------------------------------------------------------
interface predictor_epoch_ctrl_if
  import predictor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] br;
  logic [CNT_W-1:0] miss;
  logic             partial;

  modport master (
    output valid,
    output br,
    output miss,
    output partial,
    input  ready
  );

  modport slave (
    input  valid,
    input  br,
    input  miss,
    input  partial,
    output ready
  );

endinterface : predictor_epoch_ctrl_if

// File: rtl/predictor_epoch_ctrl_epoch_counter.sv
// -----------------------------------------------------------------------------
// epoch_counter
// Saturating branch/miss counter pair with synchronous clear and enable.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero both counters next cycle (wins over en)
//   en         : count one branch this cycle
//   miss       : the counted branch was mispredicted
//   br_nxt     : branch count including this cycle's branch
//   miss_nxt   : miss count including this cycle's branch
// The *_nxt outputs let the parent snapshot a completing branch in the same
// cycle it is counted.
// -----------------------------------------------------------------------------
module epoch_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             miss,
  output logic [CNT_W-1:0] br_nxt,
  output logic [CNT_W-1:0] miss_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] br_cnt_q,   br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    br_nxt   = br_cnt_q;
    miss_nxt = miss_cnt_q;
    if (en && (br_cnt_q != CNT_MAX)) begin
      br_nxt = br_cnt_q + CNT_W'(1);
    end
    if (en && miss && (miss_cnt_q != CNT_MAX)) begin
      miss_nxt = miss_cnt_q + CNT_W'(1);
    end
    br_cnt_d   = clr ? '0 : br_nxt;
    miss_cnt_d = clr ? '0 : miss_nxt;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule : epoch_counter

// File: rtl/predictor_epoch_ctrl.sv
// -----------------------------------------------------------------------------
// predictor_epoch_ctrl
// Measures branch prediction quality in fixed-length epochs and reports a
// branch/miss snapshot per epoch; requests retraining when an epoch's misses
// exceed a threshold.
//   clk, reset   : clock, synchronous active-high reset
//   start, stop  : single-cycle pulses to begin / end measurement
//   br_valid     : one resolved branch this cycle
//   br_success   : prediction was correct (qualified by br_valid)
//   epoch_len    : branches per epoch, latched on start and at each boundary
//   miss_thresh  : miss count above which retrain is pulsed
//   rpt          : report channel (master side)
//   retrain      : one-cycle retraining request
//   overrun      : sticky, an unaccepted report was overwritten
//   busy         : controller not idle
// -----------------------------------------------------------------------------
module predictor_epoch_ctrl
  import predictor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  br_valid,
  input  logic                  br_success,
  input  logic [CNT_W-1:0]      epoch_len,
  input  logic [CNT_W-1:0]      miss_thresh,
  predictor_epoch_ctrl_if.master rpt,
  output logic                  retrain,
  output logic                  overrun,
  output logic                  busy
);

  state_e           state_q,       state_d;
  logic [CNT_W-1:0] len_q,         len_d;
  logic             rpt_valid_q,   rpt_valid_d;
  logic [CNT_W-1:0] rpt_br_q,      rpt_br_d;
  logic [CNT_W-1:0] rpt_miss_q,    rpt_miss_d;
  logic             rpt_partial_q, rpt_partial_d;
  logic             retrain_q,     retrain_d;
  logic             overrun_q,     overrun_d;
  // A stop that coincides with an epoch completion owes a zero partial report
  // once the full report has been loaded.
  logic             pend_q,        pend_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] br_nxt;
  logic [CNT_W-1:0] miss_nxt;
  logic             accept;
  logic             done;
  logic             load;
  logic [CNT_W-1:0] load_br;
  logic [CNT_W-1:0] load_miss;
  logic             load_partial;

  epoch_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .miss     (~br_success),
    .br_nxt   (br_nxt),
    .miss_nxt (miss_nxt)
  );

  assign accept = rpt_valid_q && rpt.ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    rpt_valid_d   = rpt_valid_q;
    rpt_br_d      = rpt_br_q;
    rpt_miss_d    = rpt_miss_q;
    rpt_partial_d = rpt_partial_q;
    retrain_d     = 1'b0;
    overrun_d     = overrun_q;
    pend_d        = pend_q;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    done          = 1'b0;
    load          = 1'b0;
    load_br       = '0;
    load_miss     = '0;
    load_partial  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          len_d     = epoch_len;
          overrun_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end

      ST_RUN: begin
        cnt_en = br_valid;
        // A latched length of zero never completes.
        done   = br_valid && (len_q != '0) && (br_nxt == len_q);
        if (done) begin
          load      = 1'b1;
          load_br   = br_nxt;
          load_miss = miss_nxt;
          retrain_d = (miss_nxt > miss_thresh);
          len_d     = epoch_len;
          cnt_clr   = 1'b1;
        end
        if (stop) begin
          state_d = ST_FLUSH;
          cnt_clr = 1'b1;
          if (done) begin
            pend_d = 1'b1;
          end else begin
            load         = 1'b1;
            load_br      = br_nxt;
            load_miss    = miss_nxt;
            load_partial = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (pend_q) begin
          // Counters were cleared at the completing branch: partial is empty.
          pend_d       = 1'b0;
          load         = 1'b1;
          load_partial = 1'b1;
        end else if (accept) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A new snapshot wins over an accept in the same cycle; it only counts as
    // an overrun when the old one is still unconsumed.
    if (load) begin
      rpt_valid_d   = 1'b1;
      rpt_br_d      = load_br;
      rpt_miss_d    = load_miss;
      rpt_partial_d = load_partial;
      if (rpt_valid_q && !accept) begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rpt_valid_d = 1'b0;
    end
  end

  // NOTE: the snapshot registers are reset too, so a pending report is
  // discarded and the outputs read zero straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_br_q      <= '0;
      rpt_miss_q    <= '0;
      rpt_partial_q <= 1'b0;
      retrain_q     <= 1'b0;
      overrun_q     <= 1'b0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_br_q      <= rpt_br_d;
      rpt_miss_q    <= rpt_miss_d;
      rpt_partial_q <= rpt_partial_d;
      retrain_q     <= retrain_d;
      overrun_q     <= overrun_d;
      pend_q        <= pend_d;
    end
  end

  assign rpt.valid   = rpt_valid_q;
  assign rpt.br      = rpt_br_q;
  assign rpt.miss    = rpt_miss_q;
  assign rpt.partial = rpt_partial_q;
  assign retrain     = retrain_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule : predictor_epoch_ctrl

// File: tb/tb_predictor_epoch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_predictor_epoch_ctrl
// Self-checking bench: a table of per-cycle {inputs, expected outputs} rows
// followed by hand-written multi-cycle sequences (stop on completion,
// saturation with zero epoch length, reset mid-epoch).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_predictor_epoch_ctrl;
  import predictor_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         br_valid;
  logic         br_success;
  logic [W-1:0] epoch_len;
  logic [W-1:0] miss_thresh;
  logic         retrain;
  logic         overrun;
  logic         busy;

  int total = 0;
  int bad   = 0;

  predictor_epoch_ctrl_if #(.CNT_W(W)) rpt_if ();

  predictor_epoch_ctrl #(.CNT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .br_valid    (br_valid),
    .br_success  (br_success),
    .epoch_len   (epoch_len),
    .miss_thresh (miss_thresh),
    .rpt         (rpt_if),
    .retrain     (retrain),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         st, sp, bv, bs, rdy;
    logic [W-1:0] len, thr;
    logic         v;
    logic [W-1:0] br, miss;
    logic         part, rt, ovr, bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int st, int sp, int bv, int bs, int rdy,
                              int len, int thr, int v, int br, int miss,
                              int part, int rt, int ovr, int bsy);
    vec_t r;
    r.st = st[0];  r.sp = sp[0];  r.bv = bv[0];  r.bs = bs[0];  r.rdy = rdy[0];
    r.len = W'(len);  r.thr = W'(thr);
    r.v = v[0];  r.br = W'(br);  r.miss = W'(miss);
    r.part = part[0];  r.rt = rt[0];  r.ovr = ovr[0];  r.bsy = bsy[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic v,
                            input logic [W-1:0] br, input logic [W-1:0] miss,
                            input logic part, input logic rt, input logic ovr,
                            input logic bsy);
    check({tag, ".rpt_valid"},   32'(rpt_if.valid),   32'(v));
    check({tag, ".rpt_br"},      32'(rpt_if.br),      32'(br));
    check({tag, ".rpt_miss"},    32'(rpt_if.miss),    32'(miss));
    check({tag, ".rpt_partial"}, 32'(rpt_if.partial), 32'(part));
    check({tag, ".retrain"},     32'(retrain),        32'(rt));
    check({tag, ".overrun"},     32'(overrun),        32'(ovr));
    check({tag, ".busy"},        32'(busy),           32'(bsy));
  endtask

  task automatic drive(input logic st, input logic sp, input logic bv,
                       input logic bs, input logic rdy);
    start        = st;
    stop         = sp;
    br_valid     = bv;
    br_success   = bs;
    rpt_if.ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen_valid;

    // st sp bv bs rdy len thr |  v  br miss part rt ovr busy
    vecs.push_back(mk(1,0,0,0,0, 4,2, 0,0,0,0,0,0,1)); // start, len 4
    vecs.push_back(mk(0,0,1,1,0, 4,2, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,0,0, 4,2, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,1,0, 4,2, 0,0,0,0,0,0,1));
    vecs.push_back(mk(0,0,1,0,0, 4,2, 1,4,2,0,0,0,1)); // 2 misses, not > 2
    vecs.push_back(mk(0,0,0,0,1, 4,1, 0,4,2,0,0,0,1)); // accept
    vecs.push_back(mk(0,0,1,1,0, 4,1, 0,4,2,0,0,0,1));
    vecs.push_back(mk(0,0,1,0,0, 4,1, 0,4,2,0,0,0,1));
    vecs.push_back(mk(0,0,1,1,0, 4,1, 0,4,2,0,0,0,1));
    vecs.push_back(mk(0,0,1,0,0, 2,1, 1,4,2,0,1,0,1)); // retrain; latch len 2
    vecs.push_back(mk(0,0,0,0,0, 2,1, 1,4,2,0,0,0,1)); // retrain one cycle, hold
    vecs.push_back(mk(0,0,0,0,1, 2,1, 0,4,2,0,0,0,1)); // accept
    vecs.push_back(mk(0,0,1,0,0, 2,1, 0,4,2,0,0,0,1));
    vecs.push_back(mk(0,0,1,1,0, 2,1, 1,2,1,0,0,0,1)); // 1 miss, not > 1
    vecs.push_back(mk(0,0,1,0,0, 2,1, 1,2,1,0,0,0,1));
    vecs.push_back(mk(0,0,1,0,1, 2,1, 1,2,2,0,1,0,1)); // complete + accept: no overrun
    vecs.push_back(mk(0,0,1,1,0, 2,1, 1,2,2,0,0,0,1));
    vecs.push_back(mk(0,0,1,1,0, 2,1, 1,2,0,0,0,1,1)); // overwritten -> overrun
    vecs.push_back(mk(0,1,0,0,0, 8,1, 1,0,0,1,0,1,1)); // stop, empty partial
    vecs.push_back(mk(0,0,0,0,1, 8,1, 0,0,0,1,0,1,0)); // accept -> IDLE
    vecs.push_back(mk(1,0,0,0,0, 8,0, 0,0,0,1,0,0,1)); // start clears overrun
    vecs.push_back(mk(0,0,1,1,0, 8,0, 0,0,0,1,0,0,1));
    vecs.push_back(mk(0,0,1,0,0, 8,0, 0,0,0,1,0,0,1));
    vecs.push_back(mk(0,1,1,1,0, 8,0, 1,3,1,1,0,0,1)); // stop counts its branch
    vecs.push_back(mk(0,0,1,0,0, 8,0, 1,3,1,1,0,0,1)); // FLUSH ignores branches
    vecs.push_back(mk(0,0,0,0,1, 8,0, 0,3,1,1,0,0,0)); // accept -> IDLE
    vecs.push_back(mk(0,1,1,0,0, 8,0, 0,3,1,1,0,0,0)); // IDLE ignores stop/br

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    epoch_len   = '0;
    miss_thresh = '0;
    tick();
    tick();
    check_outs("reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_outs("post_reset", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].bv, vecs[i].bs, vecs[i].rdy);
      epoch_len   = vecs[i].len;
      miss_thresh = vecs[i].thr;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].v, vecs[i].br, vecs[i].miss,
                 vecs[i].part, vecs[i].rt, vecs[i].ovr, vecs[i].bsy);
    end

    // Stop in the completing cycle: full report, then an empty partial
    epoch_len   = 16'd2;
    miss_thresh = 16'd5;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  tick();
    check_outs("stopdone.full", 1'b1, 16'd2, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  tick();
    check_outs("stopdone.partial", 1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  tick();
    check_outs("stopdone.idle", 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Zero epoch length: counters saturate, no report until stop
    epoch_len   = 16'd0;
    miss_thresh = 16'd0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  tick();
    seen_valid = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (rpt_if.valid !== 1'b0) seen_valid = 1'b1;
    end
    check("sat.no_report", 32'(seen_valid), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  tick();
    check_outs("sat.stop", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  tick();
    check_outs("sat.idle", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-epoch with a pending report
    epoch_len = 16'd2;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  tick();
    tick();
    check_outs("rst.pending", 1'b1, 16'd2, 16'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);  tick();
    check_outs("rst.cleared", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  tick();
    check_outs("rst.idle", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_predictor_epoch_ctrl

// File: doc/predictor_epoch_ctrl.md
PREDICTOR_EPOCH_CTRL -- requirements
Module: predictor_epoch_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of all branch/miss counters and snapshots.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse; begins epoch measurement from IDLE.
REQ-005 stop  input  1  single-cycle pulse; ends measurement after a final partial report.
REQ-006 br_valid  input  1  one resolved branch this cycle.
REQ-007 br_success  input  1  prediction correct (qualified by br_valid).
REQ-008 epoch_len  input  CNT_W  branches per epoch; sampled on start and at each epoch boundary.
REQ-009 miss_thresh  input  CNT_W  miss count above which retraining is requested.
REQ-010 rpt_valid  output  1  snapshot available.
REQ-011 rpt_ready  input  1  consumer accepts snapshot when rpt_valid and rpt_ready are both 1.
REQ-012 rpt_br  output  CNT_W  branches in reported epoch.
REQ-013 rpt_miss  output  CNT_W  misses in reported epoch.
REQ-014 rpt_partial  output  1  report produced by stop, not by epoch completion.
REQ-015 retrain  output  1  one-cycle pulse requesting predictor retraining.
REQ-016 overrun  output  1  sticky; an unaccepted report was overwritten.
REQ-017 busy  output  1  FSM not in IDLE.

Function
REQ-018 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH on stop; FLUSH->IDLE on report accept; start ignored outside IDLE; stop ignored outside RUN.
REQ-019 In RUN, br_valid increments br_cnt; br_valid with br_success=0 also increments miss_cnt.
REQ-020 Counters saturate at 2^CNT_W-1, never wrap.
REQ-021 Epoch completes in the cycle where a counted branch makes br_cnt equal the latched epoch_len.
REQ-022 On completion: snapshot (including the completing branch) loads rpt_br/rpt_miss, rpt_partial=0, rpt_valid=1 from next cycle; counters restart at 0 in that same next cycle, with no branch lost.
REQ-023 On completion with final miss count > miss_thresh, retrain=1 for exactly the cycle after completion.
REQ-024 Latched epoch_len of 0 means no completion; counters saturate until stop.
REQ-025 rpt_* hold stable while rpt_valid=1 and rpt_ready=0; rpt_valid clears the cycle after accept.
REQ-026 Completion while rpt_valid=1 and not accepted that cycle: snapshot overwritten with newest, overrun set.
REQ-027 Completion in the same cycle as accept: new snapshot loads, rpt_valid stays 1, no overrun.
REQ-028 stop in RUN: branch in the stop cycle is counted; partial snapshot loads next cycle with rpt_partial=1; retrain never asserted for partial reports.
REQ-029 stop in the same cycle as a completion: full report is taken, then FLUSH issues a partial report with rpt_br=0, rpt_miss=0.
REQ-030 In FLUSH, if a prior report is unaccepted, it is overwritten by the partial report and overrun is set.
REQ-031 In FLUSH and IDLE, br_valid is ignored; overrun clears only on reset or start.

Reset
REQ-032 reset: state=IDLE, br_cnt=0, miss_cnt=0, rpt_valid=0, rpt_br=0, rpt_miss=0, rpt_partial=0, retrain=0, overrun=0, busy=0.
REQ-033 reset takes priority over all inputs, including mid-epoch and during an unaccepted report; pending snapshot discarded.

Structure
REQ-034 Shared package predictor_pkg holds the FSM state enum and CNT_W default.
REQ-035 One sub-module, epoch_counter: saturating br/miss counter pair with synchronous clear and enable.

Verification
REQ-036 epoch_len=4, start, 4 branches with success 1,0,1,0 -> rpt_valid next cycle, rpt_br=4, rpt_miss=2, retrain=0 (miss_thresh=2).
REQ-037 Same with miss_thresh=1 -> retrain pulses one cycle, aligned with rpt_valid rise.
REQ-038 epoch_len=2, rpt_ready=0, 4 branches -> second snapshot rpt_br=2 replaces first, overrun=1.
REQ-039 epoch_len=8, 3 branches (1 miss), stop -> rpt_partial=1, rpt_br=3, rpt_miss=1; accept -> IDLE, busy=0.
REQ-040 epoch_len=0, 70000 misses -> rpt_valid stays 0; stop -> rpt_br=rpt_miss=16'hFFFF.
REQ-041 reset mid-epoch with rpt_valid=1 -> next cycle all outputs zero, state IDLE.
